// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow, asynchronous
// clock-like input in clk cycles, flags lock on a stable period and flags
// overflow when the input stops toggling.
//
// state | meaning
// IDLE  | disabled; counters held at zero
// ARM   | waiting for the first rising edge of the synchronized input
// MEAS  | counting period/high time between consecutive rising edges
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int LOCK_N      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_N);
  localparam logic [MW-1:0]    M_ONE    = MW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic                   rise;

  logic [CNT_W-1:0] p_cnt, p_nxt;
  logic [CNT_W-1:0] h_cnt, h_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             mv_nxt, locked_nxt, ovf_nxt;
  logic [MW-1:0]    match_cnt, match_nxt, match_new;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev;

  // Synchronize sig_in and keep one cycle of history for edge detection;
  // runs regardless of enable so history is valid on re-enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s;
    end
  end

  // State, counters and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      p_cnt      <= '0;
      h_cnt      <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      p_cnt      <= p_nxt;
      h_cnt      <= h_nxt;
      period     <= period_nxt;
      high_time  <= high_nxt;
      meas_valid <= mv_nxt;
      match_cnt  <= match_nxt;
      locked     <= locked_nxt;
      overflow   <= ovf_nxt;
    end
  end

  // Next-state and datapath decisions; a rise beats counter saturation.
  always_comb begin
    state_nxt  = state;
    p_nxt      = p_cnt;
    h_nxt      = h_cnt;
    period_nxt = period;
    high_nxt   = high_time;
    mv_nxt     = 1'b0;
    match_nxt  = match_cnt;
    locked_nxt = locked;
    ovf_nxt    = overflow;
    match_new  = M_ONE;

    // match_cnt == 0 marks the first result since arming
    if ((match_cnt != '0) && (p_cnt == period)) begin
      match_new = (match_cnt >= LOCK_TGT) ? LOCK_TGT : match_cnt + M_ONE;
    end

    if (!enable) begin
      state_nxt  = IDLE;
      p_nxt      = '0;
      h_nxt      = '0;
      match_nxt  = '0;
      locked_nxt = 1'b0;
      ovf_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          p_nxt     = '0;
          h_nxt     = '0;
          state_nxt = ARM;
        end
        ARM: begin
          if (rise) begin
            state_nxt = MEAS;
            p_nxt     = CNT_ONE;
            h_nxt     = CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            period_nxt = p_cnt;
            high_nxt   = h_cnt;
            mv_nxt     = 1'b1;
            p_nxt      = CNT_ONE;
            h_nxt      = CNT_ONE;
            match_nxt  = match_new;
            locked_nxt = (match_new >= LOCK_TGT);
          end else if (p_cnt == CNT_MAX) begin
            ovf_nxt    = 1'b1;
            locked_nxt = 1'b0;
            match_nxt  = '0;
            p_nxt      = '0;
            h_nxt      = '0;
            state_nxt  = ARM;
          end else begin
            p_nxt = p_cnt + CNT_ONE;
            h_nxt = h_cnt + {{(CNT_W-1){1'b0}}, s};
          end
        end
        default: begin
          state_nxt = IDLE;
          p_nxt     = '0;
          h_nxt     = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed sig_in waveforms, expected
// results queued at each stimulus rising edge, checked by a monitor.
module tb_clk_period_meter;

  localparam int CNT_W  = 8;
  localparam int LOCK_N = 4;
  localparam int SYNC   = 2;

  logic             clk;
  logic             reset;
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             overflow;

  clk_period_meter #(
    .CNT_W(CNT_W),
    .LOCK_N(LOCK_N),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sig_in(sig_in),
    .enable(enable),
    .period(period),
    .high_time(high_time),
    .meas_valid(meas_valid),
    .locked(locked),
    .overflow(overflow)
  );

  typedef struct {
    int per;
    int hi_lo;
    int hi_hi;
    bit lock;
    bit chk_gap;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model state
  bit m_started;
  int m_last_per, m_last_lo, m_last_hi;
  bit m_prev_valid;
  int m_prev_res;
  int m_match;

  initial clk = 1'b0;
  // 10 time-unit system clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_arm();
    m_started    = 1'b0;
    m_prev_valid = 1'b0;
    m_match      = 0;
  endtask

  // called at each stimulus rising edge; the previous chunk becomes a result
  task automatic rise_event(input int per, input int lo, input int hi);
    exp_t e;
    if (m_started) begin
      if (!m_prev_valid || m_last_per != m_prev_res) m_match = 1;
      else if (m_match < LOCK_N) m_match++;
      e.per     = m_last_per;
      e.hi_lo   = m_last_lo;
      e.hi_hi   = m_last_hi;
      e.lock    = (m_match >= LOCK_N);
      e.chk_gap = m_prev_valid;
      q.push_back(e);
      m_prev_res   = m_last_per;
      m_prev_valid = 1'b1;
    end
    m_last_per = per;
    m_last_lo  = lo;
    m_last_hi  = hi;
    m_started  = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one posedge-aligned period of sig_in: hi cycles high, rest low
  task automatic drive_period(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      if (i == 0) rise_event(per, hi, hi);
      sig_in = (i < hi);
      @(posedge clk);
      #1;
    end
  endtask

  // odd divide-by-9 output with 50% duty: high for 4.5 clk cycles
  task automatic div9_periods(input int n);
    for (int i = 0; i < n; i++) begin
      rise_event(9, 4, 5);
      sig_in = 1'b1;
      #45;
      sig_in = 1'b0;
      #45;
    end
  endtask

  // monitor: pops and compares on every meas_valid
  int cyc = 0;
  int last_mv = 0;
  bit prev_mv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      prev_mv = 1'b0;
    end else begin
      if (meas_valid === 1'b1) begin
        checks++;
        if (prev_mv) begin
          failures++;
          $display("FAIL valid_width actual=2+ cycles expected=1 cycle");
        end
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual period=%0d expected=no result", period);
        end else begin
          e = q.pop_front();
          chk("period", int'(period), e.per);
          checks++;
          if (int'(high_time) < e.hi_lo || int'(high_time) > e.hi_hi) begin
            failures++;
            $display("FAIL high_time actual=%0d expected=%0d..%0d", high_time, e.hi_lo, e.hi_hi);
          end
          chk("locked_at_valid", int'(locked), int'(e.lock));
          if (e.chk_gap) chk("valid_spacing", cyc - last_mv, e.per);
        end
        last_mv = cyc;
      end
      prev_mv = (meas_valid === 1'b1);
    end
  end

  initial begin
    int n;
    int w;
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    model_arm();

    // reset with sig_in toggling
    repeat (3) begin
      @(posedge clk);
      #1;
      sig_in = ~sig_in;
    end
    @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    sig_in = 1'b0;
    n = 0;
    repeat (SYNC + 2) begin
      @(negedge clk);
      if (meas_valid === 1'b1) n++;
    end
    chk("no_valid_disabled", n, 0);

    // basic measurement, lock on period 9, then unlock/relock on period 7
    @(posedge clk);
    #1;
    enable = 1'b1;
    model_arm();
    wait_cycles(2);
    repeat (6) drive_period(9, 4);
    repeat (5) drive_period(7, 3);

    // overflow: one rise, then hold low
    rise_event(1, 1, 1);
    sig_in = 1'b1;
    wait_cycles(1);
    sig_in = 1'b0;
    w = 0;
    while (overflow !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("overflow_set", int'(overflow), 1);
    checks++;
    if (w < 254 || w > 262) begin
      failures++;
      $display("FAIL overflow_time actual=%0d expected=254..262 cycles", w);
    end
    chk("ovf_period_held", int'(period), 7);
    chk("ovf_locked", int'(locked), 0);
    model_arm();
    @(posedge clk);
    #1;
    repeat (3) drive_period(5, 2);
    wait_cycles(2);
    @(negedge clk);
    chk("overflow_sticky", int'(overflow), 1);
    chk("period_after_ovf", int'(period), 5);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("overflow_clr_enable", int'(overflow), 0);

    // enable drop mid-period while locked
    @(posedge clk);
    #1;
    enable = 1'b1;
    model_arm();
    wait_cycles(2);
    repeat (5) drive_period(9, 4);
    rise_event(9, 4, 4);
    sig_in = 1'b1;
    wait_cycles(4);
    sig_in = 1'b0;
    wait_cycles(2);
    chk("locked_before_drop", int'(locked), 1);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_locked", int'(locked), 0);
    chk("drop_meas_valid", int'(meas_valid), 0);
    chk("drop_period_held", int'(period), 9);
    @(posedge clk);
    #1;
    enable = 1'b1;
    model_arm();
    wait_cycles(2);
    repeat (3) drive_period(9, 4);

    // divider integration
    enable = 1'b0;
    wait_cycles(1);
    enable = 1'b1;
    model_arm();
    wait_cycles(2);
    div9_periods(6);
    wait_cycles(12);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
